// File: rtl/redmule_feedback_buffer_pkg.sv
// Shared types for the RedMulE feedback buffer: FSM state encoding and the
// bundled control inputs that drive it.
package redmule_feedback_buffer_pkg;

    // Width at which k_iters travels inside fb_ctrl_t; KCntW must not exceed it.
    localparam int FB_KCNT_W = 16;

    typedef enum logic [1:0] {
        FB_IDLE  = 2'd0,
        FB_LOAD  = 2'd1,
        FB_ACCUM = 2'd2,
        FB_DRAIN = 2'd3
    } fb_state_e;

    typedef struct packed {
        logic                 start;
        logic                 clear;
        logic [FB_KCNT_W-1:0] k_iters;
        logic                 y_zero;
    } fb_ctrl_t;

endpackage

// File: rtl/redmule_fb_slots.sv
// Slot register file for the feedback buffer: Depth vectors, one write port,
// one combinational read port, and a per-slot full flag.
module redmule_fb_slots #(
    parameter int Width = 8,
    parameter int BITW  = 16,
    parameter int Depth = 4,
    parameter int PtrW  = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    i_we,
    input  logic [PtrW-1:0]         i_waddr,
    input  logic [Width*BITW-1:0]   i_wdata,
    input  logic                    i_clr_all,
    input  logic                    i_clr_en,
    input  logic [PtrW-1:0]         i_clr_idx,
    input  logic [PtrW-1:0]         i_raddr,
    output logic [Width*BITW-1:0]   o_rdata,
    output logic [Depth-1:0]        o_full
);

    logic [Width*BITW-1:0] r_mem [Depth];
    logic [Depth-1:0]      r_full;

    // Slot data: written verbatim, never cleared except by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) r_mem[i] <= '0;
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Full flags: bulk clear wins, then a write sets, then an issue clears.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_full <= '0;
        end else begin
            for (int i = 0; i < Depth; i++) begin
                if (i_clr_all) begin
                    r_full[i] <= 1'b0;
                end else if (i_we && i_waddr == PtrW'(i)) begin
                    r_full[i] <= 1'b1;
                end else if (i_clr_en && i_clr_idx == PtrW'(i)) begin
                    r_full[i] <= 1'b0;
                end
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];
    assign o_full  = r_full;

endmodule

// File: rtl/redmule_feedback_buffer.sv
// Multi-slot partial-result store between the FMA rows and the streamer.
// Loads bias vectors, recirculates Depth interleaved tiles for k_iters passes,
// then drains the final vectors.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   FB_IDLE  | waiting for start; slot data still readable
//   FB_LOAD  | writing bias (or zero) into slots 0..Depth-1
//   FB_ACCUM | issuing slots to the rows and absorbing returned results
//   FB_DRAIN | streaming slots 0..Depth-1 out on z, then done pulse
module redmule_feedback_buffer
    import redmule_feedback_buffer_pkg::*;
#(
    parameter int Width = 8,
    parameter int BITW  = 16,
    parameter int Depth = 4,
    parameter int KCntW = FB_KCNT_W,
    localparam int PtrW  = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int DataW = Width * BITW
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             start_i,
    input  logic [KCntW-1:0] k_iters_i,
    input  logic             y_zero_i,
    input  logic             y_valid_i,
    output logic             y_ready_o,
    input  logic [DataW-1:0] y_bias_i,
    output logic             fb_valid_o,
    input  logic             fb_ready_i,
    output logic [DataW-1:0] feedback_o,
    output logic [PtrW-1:0]  fb_slot_o,
    input  logic             res_valid_i,
    input  logic [DataW-1:0] result_i,
    output logic             z_valid_o,
    input  logic             z_ready_i,
    output logic [DataW-1:0] z_output_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    // Wide enough that k_iters*Depth never wraps.
    localparam int CntW = KCntW + PtrW;
    localparam logic [PtrW-1:0] LastSlot = PtrW'(Depth - 1);

    fb_ctrl_t         w_ctrl;
    fb_state_e        r_state, w_state_nxt;
    logic [KCntW-1:0] r_k_iters, r_pass_cnt;
    logic             r_y_zero, r_err, r_done;
    logic [PtrW-1:0]  r_wr_ptr, r_rd_ptr, r_ret_ptr;
    logic [CntW-1:0]  r_issued, r_returned, w_total;
    logic             w_y_ready, w_fb_valid, w_z_valid, w_load_we;
    logic             w_fb_hs, w_z_hs, w_res_ok, w_res_bad;
    logic             w_slot_we, w_clr_all;
    logic [PtrW-1:0]  w_waddr;
    logic [DataW-1:0] w_wdata, w_rdata;
    logic [Depth-1:0] w_full;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastSlot) ? '0 : p + PtrW'(1);
    endfunction

    assign w_ctrl = '{start: start_i, clear: clear_i,
                      k_iters: FB_KCNT_W'(k_iters_i), y_zero: y_zero_i};

    assign w_total = CntW'(r_k_iters) * CntW'(Depth);

    // Next-state decode and valid/ready generation from registered state only.
    always_comb begin
        w_state_nxt = r_state;
        w_y_ready   = 1'b0;
        w_fb_valid  = 1'b0;
        w_z_valid   = 1'b0;
        w_load_we   = 1'b0;
        case (r_state)
            FB_IDLE: begin
                if (w_ctrl.start) w_state_nxt = FB_LOAD;
            end
            FB_LOAD: begin
                w_y_ready = ~r_y_zero;
                w_load_we = r_y_zero | y_valid_i;
                if (w_load_we && r_wr_ptr == LastSlot)
                    w_state_nxt = (r_k_iters == '0) ? FB_DRAIN : FB_ACCUM;
            end
            FB_ACCUM: begin
                w_fb_valid = w_full[r_rd_ptr] && (r_issued < w_total);
                if (r_pass_cnt == r_k_iters) w_state_nxt = FB_DRAIN;
            end
            FB_DRAIN: begin
                w_z_valid = 1'b1;
                if (z_ready_i && r_rd_ptr == LastSlot) w_state_nxt = FB_IDLE;
            end
            default: w_state_nxt = FB_IDLE;
        endcase
        if (w_ctrl.clear) w_state_nxt = FB_IDLE;
    end

    assign w_fb_hs   = w_fb_valid & fb_ready_i;
    assign w_z_hs    = w_z_valid & z_ready_i;
    // A result is only legal in ACCUM with something outstanding; anything else is dropped.
    assign w_res_ok  = res_valid_i && (r_state == FB_ACCUM) && (r_issued != r_returned);
    assign w_res_bad = res_valid_i & ~w_res_ok;

    assign w_slot_we = ~w_ctrl.clear & (w_load_we | w_res_ok);
    assign w_waddr   = (r_state == FB_LOAD) ? r_wr_ptr : r_ret_ptr;
    assign w_wdata   = (r_state == FB_LOAD) ? (r_y_zero ? '0 : y_bias_i) : result_i;
    assign w_clr_all = w_ctrl.clear | ((r_state == FB_IDLE) & w_ctrl.start);

    redmule_fb_slots #(
        .Width (Width),
        .BITW  (BITW),
        .Depth (Depth),
        .PtrW  (PtrW)
    ) u_slots (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .i_we      (w_slot_we),
        .i_waddr   (w_waddr),
        .i_wdata   (w_wdata),
        .i_clr_all (w_clr_all),
        .i_clr_en  (w_fb_hs & ~w_ctrl.clear),
        .i_clr_idx (r_rd_ptr),
        .i_raddr   (r_rd_ptr),
        .o_rdata   (w_rdata),
        .o_full    (w_full)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= FB_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Job configuration, pointers, counters, done pulse and sticky error.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_k_iters  <= '0;
            r_y_zero   <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ret_ptr  <= '0;
            r_issued   <= '0;
            r_returned <= '0;
            r_pass_cnt <= '0;
            r_err      <= 1'b0;
            r_done     <= 1'b0;
        end else if (w_ctrl.clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ret_ptr  <= '0;
            r_issued   <= '0;
            r_returned <= '0;
            r_pass_cnt <= '0;
            r_err      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_res_bad) r_err <= 1'b1;
            case (r_state)
                FB_IDLE: begin
                    if (w_ctrl.start) begin
                        r_k_iters  <= KCntW'(w_ctrl.k_iters);
                        r_y_zero   <= w_ctrl.y_zero;
                        r_wr_ptr   <= '0;
                        r_rd_ptr   <= '0;
                        r_ret_ptr  <= '0;
                        r_issued   <= '0;
                        r_returned <= '0;
                        r_pass_cnt <= '0;
                    end
                end
                FB_LOAD: begin
                    if (w_load_we) r_wr_ptr <= ptr_inc(r_wr_ptr);
                end
                FB_ACCUM: begin
                    if (w_fb_hs) begin
                        r_rd_ptr <= ptr_inc(r_rd_ptr);
                        r_issued <= r_issued + CntW'(1);
                    end
                    if (w_res_ok) begin
                        r_ret_ptr  <= ptr_inc(r_ret_ptr);
                        r_returned <= r_returned + CntW'(1);
                        if (r_ret_ptr == LastSlot) r_pass_cnt <= r_pass_cnt + KCntW'(1);
                    end
                end
                FB_DRAIN: begin
                    if (w_z_hs) begin
                        r_rd_ptr <= ptr_inc(r_rd_ptr);
                        if (r_rd_ptr == LastSlot) r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign y_ready_o  = w_y_ready;
    assign fb_valid_o = w_fb_valid;
    assign z_valid_o  = w_z_valid;
    assign feedback_o = w_rdata;
    assign z_output_o = w_rdata;
    assign fb_slot_o  = r_rd_ptr;
    assign busy_o     = (r_state != FB_IDLE);
    assign done_o     = r_done;
    assign err_o      = r_err;

endmodule

// File: tb/tb_redmule_feedback_buffer.sv
// Self-checking bench for redmule_feedback_buffer. A model row returns
// feedback+1 per lane after a fixed latency; expected slot contents are
// computed as bias + (pass count) per lane.
module tb_redmule_feedback_buffer;

    localparam int W  = 8;
    localparam int BW = 16;
    localparam int D  = 4;
    localparam int KW = 16;
    localparam int PW = 2;
    localparam int DW = W * BW;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          clear_i = 1'b0;
    logic          start_i = 1'b0;
    logic [KW-1:0] k_iters_i = '0;
    logic          y_zero_i = 1'b0;
    logic          y_valid_i = 1'b0;
    logic          y_ready_o;
    logic [DW-1:0] y_bias_i = '0;
    logic          fb_valid_o;
    logic          fb_ready_i = 1'b0;
    logic [DW-1:0] feedback_o;
    logic [PW-1:0] fb_slot_o;
    logic          res_valid_i = 1'b0;
    logic [DW-1:0] result_i = '0;
    logic          z_valid_o;
    logic          z_ready_i = 1'b0;
    logic [DW-1:0] z_output_o;
    logic          busy_o, done_o, err_o;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] bias [D];
    logic [DW-1:0] last_slot0 = '0;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } ret_t;

    always #5 clk_i = ~clk_i;

    redmule_feedback_buffer dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .start_i     (start_i),
        .k_iters_i   (k_iters_i),
        .y_zero_i    (y_zero_i),
        .y_valid_i   (y_valid_i),
        .y_ready_o   (y_ready_o),
        .y_bias_i    (y_bias_i),
        .fb_valid_o  (fb_valid_o),
        .fb_ready_i  (fb_ready_i),
        .feedback_o  (feedback_o),
        .fb_slot_o   (fb_slot_o),
        .res_valid_i (res_valid_i),
        .result_i    (result_i),
        .z_valid_o   (z_valid_o),
        .z_ready_i   (z_ready_i),
        .z_output_o  (z_output_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    function automatic logic [DW-1:0] add_k(input logic [DW-1:0] v, input int k);
        logic [DW-1:0] r;
        r = '0;
        for (int l = 0; l < W; l++) r[l*BW +: BW] = v[l*BW +: BW] + BW'(k);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_y_ready"},  DW'(y_ready_o),  '0);
        chk({tag, "_fb_valid"}, DW'(fb_valid_o), '0);
        chk({tag, "_z_valid"},  DW'(z_valid_o),  '0);
        chk({tag, "_busy"},     DW'(busy_o),     '0);
        chk({tag, "_done"},     DW'(done_o),     '0);
        chk({tag, "_err"},      DW'(err_o),      '0);
        chk({tag, "_feedback"}, feedback_o,      '0);
        chk({tag, "_z_output"}, z_output_o,      '0);
        chk({tag, "_fb_slot"},  DW'(fb_slot_o),  '0);
    endtask

    // One job: start, load, accumulate through the model row, drain.
    // stop_after>0 aborts after that many issues (clear, or reset if stop_rst).
    task automatic run_job(input int k, input bit zero, input int lat, input bit bp,
                           input int stop_after, input bit stop_rst);
        ret_t          q[$];
        ret_t          tmp;
        int            n_iss = 0, n_z = 0, ld = 0, cyc = 0;
        bit            stall_fb = 0, stall_z = 0;
        logic [DW-1:0] prev_fb = '0, prev_z = '0;
        logic [PW-1:0] prev_slot = '0;
        logic [DW-1:0] base [D];
        for (int s = 0; s < D; s++) base[s] = zero ? '0 : bias[s];

        @(negedge clk_i);
        start_i   = 1'b1;
        k_iters_i = KW'(k);
        y_zero_i  = zero;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("busy_after_start", DW'(busy_o), DW'(1));

        forever begin
            if (done_o || cyc >= 3000) break;
            if (stall_fb) begin
                chk("fb_hold",        DW'(fb_valid_o), DW'(1));
                chk("fb_stable",      feedback_o, prev_fb);
                chk("fb_slot_stable", DW'(fb_slot_o), DW'(prev_slot));
            end
            if (stall_z) begin
                chk("z_hold",   DW'(z_valid_o), DW'(1));
                chk("z_stable", z_output_o, prev_z);
            end
            if (stop_after > 0 && n_iss >= stop_after) begin
                fb_ready_i  = 1'b0;
                z_ready_i   = 1'b0;
                y_valid_i   = 1'b0;
                res_valid_i = 1'b0;
                if (stop_rst) begin
                    rst_ni = 1'b0;
                    #1;
                    check_reset_outputs("rst_mid");
                    @(negedge clk_i);
                    rst_ni = 1'b1;
                end else begin
                    clear_i = 1'b1;
                    @(negedge clk_i);
                    clear_i = 1'b0;
                    chk("abort_busy",     DW'(busy_o),     '0);
                    chk("abort_fb_valid", DW'(fb_valid_o), '0);
                    chk("abort_err",      DW'(err_o),      '0);
                end
                @(negedge clk_i);
                chk("idle_after_stop", DW'(busy_o), '0);
                return;
            end

            if (!zero && ld < D) begin
                y_valid_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                y_bias_i  = bias[ld];
            end else begin
                y_valid_i = 1'b0;
            end
            if (y_valid_i && y_ready_o) ld++;

            res_valid_i = 1'b0;
            if (q.size() > 0 && q[0].due == cyc) begin
                tmp         = q.pop_front();
                res_valid_i = 1'b1;
                result_i    = tmp.data;
            end

            fb_ready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (fb_valid_o && fb_ready_i) begin
                chk("fb_slot", DW'(fb_slot_o), DW'(n_iss % D));
                chk("fb_data", feedback_o, add_k(base[n_iss % D], n_iss / D));
                q.push_back('{due: cyc + lat, data: add_k(feedback_o, 1)});
                n_iss++;
            end
            stall_fb  = fb_valid_o && !fb_ready_i;
            prev_fb   = feedback_o;
            prev_slot = fb_slot_o;

            z_ready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (z_valid_o && z_ready_i) begin
                chk("z_data", z_output_o, add_k(base[n_z % D], k));
                n_z++;
            end
            stall_z = z_valid_o && !z_ready_i;
            prev_z  = z_output_o;

            @(negedge clk_i);
            cyc++;
        end

        fb_ready_i  = 1'b0;
        z_ready_i   = 1'b0;
        y_valid_i   = 1'b0;
        res_valid_i = 1'b0;
        chk("job_done",       DW'(done_o), DW'(1));
        chk("issue_count",    DW'(n_iss), DW'(k * D));
        chk("drain_count",    DW'(n_z), DW'(D));
        chk("no_outstanding", DW'(q.size()), '0);
        chk("idle_at_done",   DW'(busy_o), '0);
        @(negedge clk_i);
        chk("done_one_cycle", DW'(done_o), '0);
        last_slot0 = add_k(base[0], k);
    endtask

    initial begin
        int k, lat;

        // Reset state
        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        check_reset_outputs("reset");
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("idle_after_reset", DW'(busy_o), '0);

        // Bias passthrough: k=0, slots hold 0x1111..0x4444 in every lane
        for (int s = 0; s < D; s++)
            for (int l = 0; l < W; l++) bias[s][l*BW +: BW] = BW'((s + 1) * 'h1111);
        run_job(0, 1'b0, 3, 1'b0, 0, 1'b0);

        // Unexpected result in IDLE: flagged and dropped, then cleared
        @(negedge clk_i);
        result_i    = {DW{1'b1}};
        res_valid_i = 1'b1;
        @(negedge clk_i);
        res_valid_i = 1'b0;
        chk("err_set",       DW'(err_o), DW'(1));
        chk("err_slot_kept", feedback_o, last_slot0);
        chk("err_idle",      DW'(busy_o), '0);
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        chk("err_cleared", DW'(err_o), '0);

        // Accumulate from zero, k=3, latency 3
        run_job(3, 1'b1, 3, 1'b0, 0, 1'b0);

        // Random jobs, each run without and then with backpressure
        for (int r = 0; r < 3; r++) begin
            for (int s = 0; s < D; s++)
                for (int l = 0; l < W; l++) bias[s][l*BW +: BW] = BW'($urandom);
            k   = int'($urandom_range(1, 4));
            lat = int'($urandom_range(1, 6));
            run_job(k, 1'b0, lat, 1'b0, 0, 1'b0);
            run_job(k, 1'b0, lat, 1'b1, 0, 1'b0);
        end

        // Abort after 5 issues, then a fresh job must complete
        run_job(3, 1'b0, 3, 1'b0, 5, 1'b0);
        run_job(2, 1'b0, 2, 1'b1, 0, 1'b0);

        // Asynchronous reset mid-ACCUM, then a fresh job must complete
        run_job(3, 1'b0, 3, 1'b0, 6, 1'b1);
        chk("err_after_rst", DW'(err_o), '0);
        run_job(1, 1'b1, 4, 1'b1, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/redmule_feedback_buffer.md
# redmule_feedback_buffer

Multi-slot partial-result store between the RedMulE FMA row array and the streamer. It generalises the single-vector accumulate/bias feedback mux to `Depth` interleaved output tiles. This keeps every pipeline stage of the rows busy during K-tiling. The block loads bias vectors, recirculates partial sums for a programmed number of passes, then drains the final vectors through a valid/ready stream.

## Interface

Parameters:
- `Width`, default 8: rows (vector lanes) W.
- `BITW`, default 16: element width in bits.
- `Depth`, default 4: slots; nominally NumPipeRegs+1.
- `KCntW`, default 16: width of the pass counters.

Ports:
- `clk_i`, in, 1: clock. One clock domain.
- `rst_ni`, in, 1: asynchronous active-low reset.
- `clear_i`, in, 1: synchronous abort to IDLE.
- `start_i`, in, 1: begin a job; sampled only in IDLE.
- `k_iters_i`, in, KCntW: accumulation passes per job; sampled at start.
- `y_zero_i`, in, 1: load zeros instead of bias; sampled at start.
- `y_valid_i` in 1 / `y_ready_o` out 1 / `y_bias_i` in W×BITW: bias stream.
- `fb_valid_o` out 1 / `fb_ready_i` in 1 / `feedback_o` out W×BITW / `fb_slot_o` out clog2(Depth): operand issued to the rows.
- `res_valid_i` in 1 / `result_i` in W×BITW: row results. Always accepted; no ready.
- `z_valid_o` out 1 / `z_ready_i` in 1 / `z_output_o` out W×BITW: drain stream.
- `busy_o`, out, 1: state is not IDLE.
- `done_o`, out, 1: one-cycle pulse after the last drain beat.
- `err_o`, out, 1: sticky; set by an unexpected result.

## Operation

- **States:** IDLE, LOAD, ACCUM, DRAIN.
- **IDLE → LOAD on `start_i`.**
  - Latch `k_iters_i` and `y_zero_i`.
  - Reset all pointers and counters.
- **LOAD**
  - With `y_zero_i`=1: write zero to slots 0..Depth-1 over Depth cycles. `y_ready_o` stays 0.
  - With `y_zero_i`=0: each y handshake writes slot `wr_ptr` and increments the pointer.
  - After Depth writes:
    - go to ACCUM if k_iters>0;
    - go to DRAIN if k_iters=0.
- **ACCUM**
  - Each slot has a `full` bit, set on load or on result return.
  - `fb_valid_o` = `full[rd_ptr]` && issued < k_iters·Depth.
  - On an fb handshake:
    - clear `full[rd_ptr]`;
    - increment `rd_ptr`, wrapping at Depth-1 → 0.
  - Results return in issue order.
    - `res_valid_i` writes `result_i` to slot `ret_ptr`, sets `full`, and increments `ret_ptr`.
    - A pass completes when `ret_ptr` wraps; it increments `pass_cnt`.
  - ACCUM → DRAIN when `pass_cnt` == k_iters.
- **DRAIN**
  - `z_output_o` = slot `rd_ptr`; `z_valid_o` = 1.
  - Each z handshake increments `rd_ptr`.
  - After Depth beats: pulse `done_o` and go to IDLE.
- **Unexpected results**
  - Condition: `res_valid_i` while the number outstanding (issued − returned) is 0, or while the state is not ACCUM.
  - Action: drop the result and set `err_o`.
  - `err_o` clears only on reset or `clear_i`.
- **`clear_i`** (highest priority)
  - Next state IDLE.
  - Clear all `full` bits, pointers, counters and `err_o`.
  - Slot data is kept.
- `start_i` outside IDLE is ignored.
- No arithmetic is performed; all values are stored verbatim.
- Issued and returned counters are KCntW+clog2(Depth) bits wide, so k_iters·Depth never overflows.

## Timing

- **Reset values**
  - All of `y_ready_o`, `fb_valid_o`, `z_valid_o`, `busy_o`, `done_o`, `err_o` are 0.
  - `feedback_o`, `z_output_o` and `fb_slot_o` are 0.
  - State is IDLE and slot storage is 0.
- `y_ready_o`, `fb_valid_o` and `z_valid_o` are combinational from registered state only. There is no path from inputs to valid/ready outputs.
- `feedback_o` and `z_output_o` are a combinational read of the slot registers. A write at edge t is visible after edge t.
- **Throughput:** one load, issue, return or drain beat per cycle.
- With round-trip latency ≤ Depth cycles, `fb_valid_o` never drops within ACCUM.
- **Simultaneous issue and return:**
  - An issue and a return on different slots are both performed.
  - A return to slot `rd_ptr` while that slot is empty sets `full`; the issue is visible the next cycle.
- Once `fb_valid_o` is high it is held until the handshake; data is stable while valid and not ready. The same applies to `z_valid_o`.
- **Minimum job latency:** start → first z beat = 1 + Depth (LOAD) + k_iters·Depth + round-trip latency.
- **Reset mid-job:** asynchronous return to the reset values above.

## Structure

- `redmule_pkg` additions:
  - `fb_state_e` (the 2-bit enum IDLE/LOAD/ACCUM/DRAIN);
  - `fb_ctrl_t` struct holding start, clear, k_iters and y_zero, for FSM wiring.
- Sub-module `redmule_fb_slots`:
  - Depth×W×BITW register file with one write port and one read port, plus full bits and per-slot write-enable.
  - The top level holds the FSM, pointers and counters.

## Test plan

- **Reset:** hold `rst_ni`=0 mid-ACCUM → all outputs 0 and `busy_o`=0 on the same edge; after release, IDLE.
- **Bias passthrough:** Depth=4, k_iters=0, biases 0x1111..0x4444 → z beats 0x1111, 0x2222, 0x3333, 0x4444, then a `done_o` pulse.
- **Accumulate:**
  - Setup: k_iters=3, `y_zero_i`=1; a model row returns feedback+1 with latency 3.
  - Expect: 12 issues with `fb_slot_o` sequence 0,1,2,3 repeated, and drain values all 3.
- **Backpressure:**
  - Stimulus: randomise `fb_ready_i` and `z_ready_i` at 50%.
  - Expect: valid is held and data stable while stalled; results identical to the no-stall run.
- **Error:** `res_valid_i` pulsed in IDLE → `err_o`=1 and slot data unchanged; a following `clear_i` → `err_o`=0.
- **Abort:** `clear_i` after 5 issues → IDLE next cycle; a new job then completes correctly.
